// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: framed bit stream in (MSB- or LSB-first),
// registered WIDTH-bit word out with valid/ready handshake and sticky error flags.
module serial_word_receiver #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic             si_start,
  input  logic             dir,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shr;
  logic [CW-1:0]    cnt;
  logic             ord;

  logic             restart;
  logic             accept;
  logic             complete;
  logic             pop;
  logic             ord_n;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_n;

  // Next shift-register value and completion detect; a start bit always begins a fresh word.
  always_comb begin
    restart  = si_valid & si_start;
    accept   = si_valid & (si_start | (state == RECV));
    ord_n    = restart ? dir : ord;
    base     = restart ? '0 : shr;
    word     = ord_n ? {si, base[WIDTH-1:1]} : {base[WIDTH-2:0], si};
    cnt_n    = restart ? CW'(1) : cnt + CW'(1);
    complete = accept & (cnt_n == CW'(WIDTH));
    pop      = po_valid & po_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shr       <= '0;
      cnt       <= '0;
      ord       <= 1'b0;
      po        <= '0;
      po_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        ord <= ord_n;
        shr <= word;
        if (complete) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt   <= cnt_n;
          state <= RECV;
        end
      end

      // Single-entry output buffer; a full buffer that is not being drained drops the new word.
      if (complete) begin
        if (!po_valid || pop) begin
          po       <= word;
          po_valid <= 1'b1;
        end
      end else if (pop) begin
        po_valid <= 1'b0;
      end

      if (complete && po_valid && !po_ready) overrun <= 1'b1;
      else if (clr_err)                      overrun <= 1'b0;

      if (restart && state == RECV) frame_err <= 1'b1;
      else if (clr_err)             frame_err <= 1'b0;
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: bit-queue reference model checked
// every cycle, plus literal expectations from directed scenarios.
module tb_serial_word_receiver;

  localparam int unsigned WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             si = 1'b0;
  logic             si_valid = 1'b0;
  logic             si_start = 1'b0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready = 1'b0;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  serial_word_receiver #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_start(si_start),
    .dir(dir), .po(po), .po_valid(po_valid), .po_ready(po_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: collect the frame's bits in arrival order, place them by bit order at the end.
  bit               m_bits[$];
  logic             m_in_frame;
  logic             m_ord;
  logic [WIDTH-1:0] m_po;
  logic             m_pv;
  logic             m_ovr;
  logic             m_ferr;

  initial begin
    logic [WIDTH-1:0] w;
    logic             pop, done, set_o, set_f;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_bits.delete();
        m_in_frame = 1'b0; m_ord = 1'b0; m_po = '0; m_pv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      end else begin
        pop = m_pv && po_ready;
        done = 1'b0; set_o = 1'b0; set_f = 1'b0; w = '0;
        if (si_valid) begin
          if (si_start) begin
            if (m_in_frame) set_f = 1'b1;
            m_bits.delete();
            m_ord = dir;
            m_in_frame = 1'b1;
            m_bits.push_back(si);
          end else if (m_in_frame) begin
            m_bits.push_back(si);
          end
          if (m_in_frame && m_bits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (m_ord) w[i] = m_bits[i];
              else       w[WIDTH-1-i] = m_bits[i];
            end
            done = 1'b1;
            m_in_frame = 1'b0;
            m_bits.delete();
          end
        end
        if (done) begin
          if (!m_pv || pop) begin m_po = w; m_pv = 1'b1; end
          else set_o = 1'b1;
        end else if (pop) begin
          m_pv = 1'b0;
        end
        if (set_o) m_ovr = 1'b1; else if (clr_err) m_ovr = 1'b0;
        if (set_f) m_ferr = 1'b1; else if (clr_err) m_ferr = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_no, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      if (rst) begin
        check("model po", 32'(po), 32'(m_po));
        check("model po_valid", 32'(po_valid), 32'(m_pv));
        check("model busy", 32'(busy), 32'(m_in_frame));
        check("model overrun", 32'(overrun), 32'(m_ovr));
        check("model frame_err", 32'(frame_err), 32'(m_ferr));
      end
    end
  end

  task automatic cyc(input logic v, input logic s, input logic b);
    si_valid = v; si_start = s; si = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // seq[WIDTH-1] is transmitted first; dir is flipped after the start bit since it must be ignored then.
  task automatic send_frame(input logic d, input logic [WIDTH-1:0] seq, input int gap);
    dir = d;
    for (int i = 0; i < WIDTH; i++) begin
      cyc(1'b1, (i == 0), seq[WIDTH-1-i]);
      dir = ~d;
      if (gap > 0 && i < WIDTH - 1) idle(gap);
    end
    si_valid = 1'b0; si_start = 1'b0;
  endtask

  task automatic drain();
    po_ready = 1'b1;
    idle(1);
    po_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] seq;
    idle(2);
    check("reset po", 32'(po), 32'(0));
    check("reset po_valid", 32'(po_valid), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    rst = 1'b1;
    idle(1);

    // Stray bit in IDLE is ignored, no flag.
    cyc(1'b1, 1'b0, 1'b1);
    idle(1);
    check("idle stray busy", 32'(busy), 32'(0));
    check("idle stray frame_err", 32'(frame_err), 32'(0));

    // 1: MSB-first back-to-back bits.
    send_frame(1'b0, 5'b10110, 0);
    check("t1 po", 32'(po), 32'(5'b10110));
    check("t1 po_valid", 32'(po_valid), 32'(1));
    check("t1 busy", 32'(busy), 32'(0));
    drain();
    check("t1 drained", 32'(po_valid), 32'(0));

    // 2: LSB-first with two-cycle gaps; busy must hold through each gap.
    dir = 1'b1;
    seq = 5'b10110;
    for (int i = 0; i < WIDTH; i++) begin
      cyc(1'b1, (i == 0), seq[WIDTH-1-i]);
      dir = 1'b0;
      if (i < WIDTH - 1) begin
        idle(2);
        check("t2 busy in gap", 32'(busy), 32'(1));
      end
    end
    si_valid = 1'b0;
    check("t2 po", 32'(po), 32'(5'b01101));
    check("t2 po_valid", 32'(po_valid), 32'(1));
    drain();

    // 3: backpressure overrun, then clear.
    send_frame(1'b0, 5'b10110, 0);
    send_frame(1'b0, 5'b00111, 0);
    check("t3 po kept", 32'(po), 32'(5'b10110));
    check("t3 overrun", 32'(overrun), 32'(1));
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    check("t3 overrun cleared", 32'(overrun), 32'(0));
    drain();

    // 4: restart mid-frame.
    dir = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("t4 frame_err", 32'(frame_err), 32'(1));
    check("t4 busy after restart", 32'(busy), 32'(1));
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    si_valid = 1'b0;
    check("t4 po", 32'(po), 32'(5'b00001));
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    check("t4 frame_err cleared", 32'(frame_err), 32'(0));
    drain();

    // 5: streaming with po_ready held high; each word visible for one cycle.
    po_ready = 1'b1;
    send_frame(1'b0, 5'b11001, 0);
    check("t5 word1", 32'(po), 32'(5'b11001));
    check("t5 word1 valid", 32'(po_valid), 32'(1));
    dir = 1'b0;
    seq = 5'b00110;
    for (int i = 0; i < WIDTH; i++) begin
      cyc(1'b1, (i == 0), seq[WIDTH-1-i]);
      if (i == 0) check("t5 word1 one cycle", 32'(po_valid), 32'(0));
    end
    si_valid = 1'b0;
    check("t5 word2", 32'(po), 32'(5'b00110));
    idle(1);
    check("t5 word2 one cycle", 32'(po_valid), 32'(0));

    // 5b: completion coinciding with a pop replaces the word with no bubble.
    po_ready = 1'b0;
    send_frame(1'b0, 5'b10101, 0);
    seq = 5'b01110;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) po_ready = 1'b1;
      cyc(1'b1, (i == 0), seq[WIDTH-1-i]);
    end
    si_valid = 1'b0;
    po_ready = 1'b0;
    check("t5b po", 32'(po), 32'(5'b01110));
    check("t5b po_valid", 32'(po_valid), 32'(1));
    check("t5b no overrun", 32'(overrun), 32'(0));

    // 6: asynchronous reset between edges, mid-frame.
    dir = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    si_valid = 1'b0; si_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6 async po", 32'(po), 32'(0));
    check("t6 async po_valid", 32'(po_valid), 32'(0));
    check("t6 async busy", 32'(busy), 32'(0));
    check("t6 async overrun", 32'(overrun), 32'(0));
    check("t6 async frame_err", 32'(frame_err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    send_frame(1'b0, 5'b01010, 0);
    check("t6 po after reset", 32'(po), 32'(5'b01010));
    check("t6 po_valid after reset", 32'(po_valid), 32'(1));
    check("t6 frame_err after reset", 32'(frame_err), 32'(0));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
